change_dispenser: RTL and testbench

Downstream actuator stage of the newspaper vending machine. Consumes the one-cycle `R`, `N1`, `D1`, `D2` outputs of the vending FSM, queues them, and drives the paper-release and coin-return solenoids one item at a time with fixed pulse and gap widths. It confirms every coin against the chute drop sensor, tracks nickel and dime inventory, and substitutes nickels when dimes run out. Timeouts and shortages are flagged to the service panel.

---
 rtl/change_dispenser.sv | 226 ++++++++++++++++++++++
 tb/tb_change_dispenser.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Actuator stage of the newspaper vending machine: queues release/coin requests and pulses the
// paper and coin solenoids one item at a time, confirming coins against the chute sensor.
module change_dispenser #(
   parameter int unsigned PULSE_CYC   = 4,
   parameter int unsigned GAP_CYC     = 2,
   parameter int unsigned ACK_TIMEOUT = 16,
   parameter int unsigned INV_W       = 6,
   parameter int unsigned INV_INIT    = 20,
   parameter int unsigned LOAD_QTY    = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic R,
   input  logic N1,
   input  logic D1,
   input  logic D2,
   input  logic drop_ack,
   input  logic load_n,
   input  logic load_d,
   output logic rel_sol,
   output logic nick_sol,
   output logic dime_sol,
   output logic busy,
   output logic nick_empty,
   output logic dime_empty,
   output logic short,
   output logic fault
);

   localparam int unsigned CNT_MAX0 = (ACK_TIMEOUT > PULSE_CYC) ? ACK_TIMEOUT : PULSE_CYC;
   localparam int unsigned CNT_MAX  = (CNT_MAX0 > GAP_CYC) ? CNT_MAX0 : GAP_CYC;
   localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
   localparam int unsigned INV_MAX  = (2 ** INV_W) - 1;

   localparam logic [CNT_W-1:0] PulseLast = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] GapLast   = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] AckLast   = CNT_W'(ACK_TIMEOUT - 1);

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StFire    = 3'd1;
   localparam logic [2:0] StWaitAck = 3'd2;
   localparam logic [2:0] StGap     = 3'd3;
   localparam logic [2:0] StFault   = 3'd4;

   localparam logic [1:0] ItemRel  = 2'd0;
   localparam logic [1:0] ItemDime = 2'd1;
   localparam logic [1:0] ItemNick = 2'd2;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       item_q, item_d;
   logic             acked_q, acked_d;
   logic             pend_rel_q, pend_rel_d;
   logic [1:0]       pend_dime_q, pend_dime_d;
   logic [2:0]       pend_nick_q, pend_nick_d;
   logic [INV_W-1:0] nick_inv_q, nick_inv_d;
   logic [INV_W-1:0] dime_inv_q, dime_inv_d;
   logic             short_q, short_d;
   logic             fault_q, fault_d;
   logic             rel_sol_q, nick_sol_q, dime_sol_q;

   logic             clr_rel, sub_dime, drop_nick, coin_done, set_fault;
   logic             dec_dime, dec_nick, inv_dec_dime, inv_dec_nick;
   logic [1:0]       dime_base;
   logic [2:0]       nick_base;
   logic [3:0]       dime_sum, nick_sum;
   logic [31:0]      nick_inv_sum, dime_inv_sum;

   // Control FSM: selects the next item by priority and times pulse, ack window and gap.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      item_d    = item_q;
      acked_d   = acked_q;
      clr_rel   = 1'b0;
      sub_dime  = 1'b0;
      drop_nick = 1'b0;
      coin_done = 1'b0;
      set_fault = 1'b0;
      case (state_q)
         StIdle: begin
            cnt_d   = '0;
            acked_d = 1'b0;
            if (pend_rel_q) begin
               state_d = StFire;
               item_d  = ItemRel;
            end else if (pend_dime_q != 2'd0) begin
               if (dime_inv_q == '0) begin
                  sub_dime = 1'b1;
               end else begin
                  state_d = StFire;
                  item_d  = ItemDime;
               end
            end else if (pend_nick_q != 3'd0) begin
               if (nick_inv_q == '0) begin
                  drop_nick = 1'b1;
               end else begin
                  state_d = StFire;
                  item_d  = ItemNick;
               end
            end
         end
         StFire: begin
            cnt_d = cnt_q + 1'b1;
            if ((item_q != ItemRel) && drop_ack && !acked_q) begin
               coin_done = 1'b1;
               acked_d   = 1'b1;
            end
            if (cnt_q == PulseLast) begin
               if (item_q == ItemRel) begin
                  clr_rel = 1'b1;
                  state_d = StGap;
                  cnt_d   = '0;
               end else if (acked_q || coin_done) begin
                  state_d = StGap;
                  cnt_d   = '0;
               end else begin
                  state_d = StWaitAck;
               end
            end
         end
         StWaitAck: begin
            // cnt keeps counting from solenoid rise, so the timeout spans FIRE too
            if (drop_ack) begin
               coin_done = 1'b1;
               state_d   = StGap;
               cnt_d     = '0;
            end else if (cnt_q == AckLast) begin
               set_fault = 1'b1;
               state_d   = StFault;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StGap: begin
            if (cnt_q == GapLast) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StFault: begin
            state_d = StFault;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   assign dec_dime     = coin_done && (item_q == ItemDime);
   assign inv_dec_dime = dec_dime;
   assign inv_dec_nick = coin_done && (item_q == ItemNick);
   assign dec_nick     = inv_dec_nick || drop_nick;

   // Pending counters: decrement first, then add the new requests, then saturate.
   always_comb begin
      pend_rel_d = (pend_rel_q && !clr_rel) || R;

      dime_base   = pend_dime_q - {1'b0, (dec_dime || sub_dime)};
      dime_sum    = {2'b00, dime_base} + {3'b000, D1} + {2'b00, D2, 1'b0};
      pend_dime_d = (dime_sum > 4'd3) ? 2'd3 : dime_sum[1:0];

      nick_base   = pend_nick_q - {2'b00, dec_nick};
      nick_sum    = {1'b0, nick_base} + {3'b000, N1} + {2'b00, sub_dime, 1'b0};
      pend_nick_d = (nick_sum > 4'd7) ? 3'd7 : nick_sum[2:0];
   end

   // Inventory: net of refill and dispense on the same edge, saturating at the counter max.
   always_comb begin
      nick_inv_sum = 32'(nick_inv_q) + (load_n ? LOAD_QTY : 32'd0) - 32'(inv_dec_nick);
      dime_inv_sum = 32'(dime_inv_q) + (load_d ? LOAD_QTY : 32'd0) - 32'(inv_dec_dime);
      nick_inv_d   = (nick_inv_sum > INV_MAX) ? INV_W'(INV_MAX) : INV_W'(nick_inv_sum);
      dime_inv_d   = (dime_inv_sum > INV_MAX) ? INV_W'(INV_MAX) : INV_W'(dime_inv_sum);
   end

   assign short_d = (short_q && !(load_n || load_d)) || drop_nick;
   assign fault_d = fault_q || set_fault;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         item_q      <= ItemRel;
         acked_q     <= 1'b0;
         pend_rel_q  <= 1'b0;
         pend_dime_q <= 2'd0;
         pend_nick_q <= 3'd0;
         nick_inv_q  <= INV_W'(INV_INIT);
         dime_inv_q  <= INV_W'(INV_INIT);
         short_q     <= 1'b0;
         fault_q     <= 1'b0;
         rel_sol_q   <= 1'b0;
         nick_sol_q  <= 1'b0;
         dime_sol_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         item_q      <= item_d;
         acked_q     <= acked_d;
         pend_rel_q  <= pend_rel_d;
         pend_dime_q <= pend_dime_d;
         pend_nick_q <= pend_nick_d;
         nick_inv_q  <= nick_inv_d;
         dime_inv_q  <= dime_inv_d;
         short_q     <= short_d;
         fault_q     <= fault_d;
         rel_sol_q   <= (state_d == StFire) && (item_d == ItemRel);
         nick_sol_q  <= (state_d == StFire) && (item_d == ItemNick);
         dime_sol_q  <= (state_d == StFire) && (item_d == ItemDime);
      end
   end

   assign rel_sol    = rel_sol_q;
   assign nick_sol   = nick_sol_q;
   assign dime_sol   = dime_sol_q;
   assign busy       = (state_q != StIdle) || pend_rel_q || (pend_dime_q != 2'd0) ||
                       (pend_nick_q != 3'd0);
   assign nick_empty = (nick_inv_q == '0);
   assign dime_empty = (dime_inv_q == '0);
   assign short      = short_q;
   assign fault      = fault_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus random request batches, checked against
// an item-level model of priority, substitution, shortage and inventory.
module tb_change_dispenser;

   localparam int PULSE = 4;
   localparam int GAP   = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic R = 1'b0, N1 = 1'b0, D1 = 1'b0, D2 = 1'b0;
   logic drop_ack = 1'b0, load_n = 1'b0, load_d = 1'b0;
   logic rel_sol, nick_sol, dime_sol, busy, nick_empty, dime_empty, short_f, fault;

   change_dispenser dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .R          (R),
      .N1         (N1),
      .D1         (D1),
      .D2         (D2),
      .drop_ack   (drop_ack),
      .load_n     (load_n),
      .load_d     (load_d),
      .rel_sol    (rel_sol),
      .nick_sol   (nick_sol),
      .dime_sol   (dime_sol),
      .busy       (busy),
      .nick_empty (nick_empty),
      .dime_empty (dime_empty),
      .short      (short_f),
      .fault      (fault)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      int kind;   // 0 release, 1 dime, 2 nickel
      int rise;
      int width;
   } pulse_t;
   pulse_t pq[$];

   int ack_en = 1;
   int ack_fixed = 0;

   // Pulse recorder and chute-sensor responder.
   logic [2:0] prev = 3'b000;
   int rise_c[3];
   int cd = 0;
   always @(negedge clk) begin
      logic [2:0] cur;
      pulse_t p;
      cur = {nick_sol, dime_sol, rel_sol};
      n_cmp++;
      assert ($onehot0(cur)) else begin
         n_err++;
         $error("FAIL sol_onehot observed=%b required=at_most_one_high", cur);
      end
      for (int i = 0; i < 3; i++) begin
         if (cur[i] && !prev[i]) rise_c[i] = cyc;
         if (!cur[i] && prev[i]) begin
            p.kind = i;
            p.rise = rise_c[i];
            p.width = cyc - rise_c[i];
            pq.push_back(p);
         end
      end
      if (drop_ack) drop_ack = 1'b0;
      if (cd > 0) begin
         cd--;
         if (cd == 0) drop_ack = 1'b1;
      end
      if (!rst_n) cd = 0;
      else if (ack_en != 0 && ((cur[1] && !prev[1]) || (cur[2] && !prev[2])))
         cd = (ack_fixed != 0) ? ack_fixed : int'($urandom_range(1, 10));
      prev = cur;
   end

   // Item-level model state
   int m_ninv, m_dinv;
   bit m_short;
   int exp_k[$];
   int skips;
   int last_k;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      {R, N1, D1, D2, load_n, load_d} = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      pq.delete();
      m_ninv = 20;
      m_dinv = 20;
      m_short = 1'b0;
   endtask

   task automatic check_static();
      chk("short", short_f, m_short);
      chk("nick_empty", nick_empty, m_ninv == 0);
      chk("dime_empty", dime_empty, m_dinv == 0);
      chk("nick_inv", dut.nick_inv_q, m_ninv);
      chk("dime_inv", dut.dime_inv_q, m_dinv);
   endtask

   task automatic check_reset_values();
      chk("rst_rel_sol", rel_sol, 0);
      chk("rst_nick_sol", nick_sol, 0);
      chk("rst_dime_sol", dime_sol, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fault", fault, 0);
      chk("rst_pend_rel", dut.pend_rel_q, 0);
      chk("rst_pend_dime", dut.pend_dime_q, 0);
      chk("rst_pend_nick", dut.pend_nick_q, 0);
      check_static();
   endtask

   // Serve everything in priority order without any notion of timing.
   task automatic model_run(input int rel, input int dm, input int nk);
      exp_k.delete();
      skips = 0;
      while (rel != 0 || dm > 0 || nk > 0) begin
         if (rel != 0) begin
            exp_k.push_back(0);
            rel = 0;
         end else if (dm > 0) begin
            dm--;
            if (m_dinv == 0) begin
               nk = (nk + 2 > 7) ? 7 : nk + 2;
               if (exp_k.size() == 0) skips++;
            end else begin
               m_dinv--;
               exp_k.push_back(1);
            end
         end else begin
            nk--;
            if (m_ninv == 0) begin
               m_short = 1'b1;
               if (exp_k.size() == 0) skips++;
            end else begin
               m_ninv--;
               exp_k.push_back(2);
            end
         end
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      @(negedge clk);
      while (busy !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("busy_falls", busy, 0);
   endtask

   task automatic compare_pulses(input int first_rise);
      chk("pulse_count", pq.size(), exp_k.size());
      for (int i = 0; i < pq.size() && i < exp_k.size(); i++) begin
         chk("pulse_kind", pq[i].kind, exp_k[i]);
         chk("pulse_width", pq[i].width, PULSE);
         if (i == 0) chk("first_rise", pq[i].rise, first_rise);
         else chk("item_spacing_ok", (pq[i].rise - pq[i-1].rise) >= PULSE + GAP + 1, 1);
      end
   endtask

   task automatic round(input bit r, input bit n1, input bit d1, input bit d2);
      int dm;
      pq.delete();
      step();
      R = r; N1 = n1; D1 = d1; D2 = d2;
      last_k = cyc;
      step();
      {R, N1, D1, D2} = '0;
      dm = int'(d1) + 2 * int'(d2);
      if (dm > 3) dm = 3;
      model_run(int'(r), dm, int'(n1));
      wait_idle(400);
      compare_pulses(last_k + 2 + skips);
      check_static();
   endtask

   task automatic load(input bit ln, input bit ld);
      step();
      load_n = ln; load_d = ld;
      step();
      load_n = 1'b0; load_d = 1'b0;
      if (ln) m_ninv = (m_ninv + 10 > 63) ? 63 : m_ninv + 10;
      if (ld) m_dinv = (m_dinv + 10 > 63) ? 63 : m_dinv + 10;
      if (ln || ld) m_short = 1'b0;
      @(negedge clk);
      check_static();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout observed=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int rise;
      int unsigned v;
      #1;
      // Reset values
      do_reset();
      @(negedge clk);
      check_reset_values();

      // Release plus one dime, ack two cycles after coin rise
      ack_fixed = 2;
      round(1'b1, 1'b0, 1'b1, 1'b0);
      if (pq.size() >= 2) chk("rel_to_dime_period", pq[1].rise - pq[0].rise, 7);
      chk("dime_inv_19", dut.dime_inv_q, 19);

      // D1+N1, then D2 while the first dime is firing
      do_reset();
      pq.delete();
      step();
      N1 = 1'b1; D1 = 1'b1;
      last_k = cyc;
      step();
      N1 = 1'b0; D1 = 1'b0;
      step();
      D2 = 1'b1;
      step();
      D2 = 1'b0;
      @(negedge clk);
      chk("pend_dime_peak", dut.pend_dime_q, 3);
      wait_idle(400);
      exp_k = '{1, 1, 1, 2};
      compare_pulses(last_k + 2);
      m_dinv = 17;
      m_ninv = 19;
      check_static();

      // Drain dimes, then D2 must come out as four nickels
      ack_fixed = 0;
      do_reset();
      repeat (7) round(1'b0, 1'b0, 1'b1, 1'b1);
      round(1'b0, 1'b0, 1'b0, 1'b1);
      chk("subst_nick_pulses", pq.size(), 4);
      chk("dime_empty_held", dime_empty, 1);

      // Nickel shortage and refill
      do_reset();
      repeat (20) round(1'b0, 1'b1, 1'b0, 1'b0);
      round(1'b0, 1'b1, 1'b0, 1'b0);
      chk("short_set", short_f, 1);
      chk("short_no_pulse", pq.size(), 0);
      load(1'b1, 1'b0);
      chk("short_cleared", short_f, 0);
      chk("nick_inv_refill", dut.nick_inv_q, 10);

      // Missing drop_ack leads to a fault at 16 cycles after solenoid rise
      do_reset();
      ack_en = 0;
      step();
      D1 = 1'b1;
      last_k = cyc;
      step();
      D1 = 1'b0;
      rise = last_k + 2;
      while (cyc < rise + 15) step();
      @(negedge clk);
      chk("fault_before_timeout", fault, 0);
      step();
      @(negedge clk);
      chk("fault_at_timeout", fault, 1);
      chk("fault_dime_sol", dime_sol, 0);
      chk("fault_busy", busy, 1);
      step();
      R = 1'b1;
      step();
      R = 1'b0;
      repeat (20) step();
      @(negedge clk);
      chk("fault_no_release", rel_sol, 0);
      chk("fault_pulses", pq.size(), 1);
      chk("fault_rel_queued", dut.pend_rel_q, 1);
      chk("fault_sticky", fault, 1);
      do_reset();
      ack_en = 1;
      @(negedge clk);
      check_reset_values();

      // Reset in the middle of a release pulse
      step();
      R = 1'b1;
      last_k = cyc;
      step();
      R = 1'b0;
      step();
      step();
      #3;
      chk("rel_mid_pulse", rel_sol, 1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_rel_sol", rel_sol, 0);
      chk("async_rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      pq.delete();
      m_ninv = 20;
      m_dinv = 20;
      m_short = 1'b0;
      repeat (15) step();
      @(negedge clk);
      chk("no_residual_pulse", pq.size(), 0);
      chk("no_residual_busy", busy, 0);
      check_static();

      // Random batches with occasional refills
      do_reset();
      for (int i = 0; i < 30; i++) begin
         v = $urandom;
         if (v[7:5] == 3'd0 && v[9:8] != 2'd0) load(v[8], v[9]);
         if (v[3:0] == 4'd0) round(1'b0, 1'b1, 1'b0, 1'b0);
         else round(v[0], v[1], v[2], v[3]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
